otbn_bignum_mul_seq: RTL and testbench
======================================

# otbn_bignum_mul_seq

Sequencer that drives the OTBN bignum MAC through a fixed 16-step quarter-word schedule to compute a full 256x256 -> 512-bit unsigned product without instruction-stream involvement. It sits beside the MAC and owns its operation and predecode inputs while busy. It captures the four 128-bit shifted-out half-words into a 512-bit result, and it aborts with an accumulator wipe on an integrity violation.

## Interface
- WLEN, 256, operand width; fixed, QWLEN = WLEN/4 = 64.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  request; accepted only in IDLE.
- operand_a_i, operand_b_i  in  WLEN  multiplicands, sampled on accept.
- stall_i  in  1  holds the current step uncommitted.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse; result_o valid.
- err_o  out  1  one-cycle pulse on abort.
- result_o  out  2*WLEN  product; held until next accept.
- mac_en_o, mac_commit_o  out  1  to MAC.
- mac_op_en_o, mac_acc_rd_en_o  out  1  predecode to MAC.
- operand_a_o, operand_b_o  out  WLEN  registered operands.
- a_qw_sel_o, b_qw_sel_o, pre_acc_shift_o  out  2  step fields.
- zero_acc_o, shift_acc_o, wr_hw_sel_upper_o  out  1  step fields.
- mac_result_i  in  WLEN  MAC operation_result.
- mac_intg_err_i, mac_predec_err_i  in  1  MAC error outputs.
- ispr_acc_wr_en_i  in  1  external ACC write, observed only.
- sec_wipe_acc_o  out  1  one-cycle accumulator wipe request.

## Operation
- States: IDLE, RUN, DONE, ABORT. Step counter 0..15 (4 bits).
- IDLE: start_i high -> latch operands, clear result_o to 0, step = 0, go to RUN. start_i is ignored in every other state.
- RUN: each cycle drives the current step's fields with mac_en_o = 1.
  - mac_commit_o = ~stall_i.
  - Step advances only on commit.
- Schedule, listed as (a_qw, b_qw, shift); "so" marks shift_acc = 1:
  - Step 0: (0,0,0), zero_acc = 1.
  - Steps 1-2: (0,1,1), (1,0,1)so.
  - Steps 3-9: (0,2,0), (1,1,0), (2,0,0), (0,3,1), (1,2,1), (2,1,1), (3,0,1)so.
  - Steps 10-14: (1,3,0), (2,2,0), (3,1,0), (2,3,1), (3,2,1)so.
  - Step 15: (3,3,0)so.
- zero_acc_o = 1 only at step 0.
- wr_hw_sel_upper_o = 1 at steps 9 and 15. It is 0 at steps 2 and 14 and at all non-so steps.
- On a committed so step, mac_result_i[127:0] is written to half-word k of result_o: k = 0, 1, 2, 3 for steps 2, 9, 14, 15.
- Predecode outputs:
  - mac_op_en_o = mac_en_o.
  - mac_acc_rd_en_o = mac_en_o & ~zero_acc_o.
  - Both are 0 outside RUN.
- Outside RUN all step fields and operand_*_o are 0 (blanked).
- Committed step 15 -> DONE. DONE asserts done_o for one cycle, then returns to IDLE.
- Abort: in RUN, any of the following -> ABORT:
  - mac_intg_err_i;
  - mac_predec_err_i;
  - ispr_acc_wr_en_i.
- ABORT behaviour:
  - The failing step is not committed (mac_commit_o forced 0 that cycle).
  - ABORT lasts one cycle with err_o = 1, sec_wipe_acc_o = 1, result_o cleared to 0.
  - Then IDLE.
- Reset: state IDLE, step 0. All outputs are 0, including result_o and the operand registers.

## Timing
- Accept in cycle 0. Steps are issued in cycles 1..16 when unstalled. done_o is in cycle 17; result_o is valid from cycle 17.
- Each stall cycle adds one cycle. Fields stay constant during a stall.
- Result half-words update on the clock edge ending their so step.
- Error inputs are sampled combinationally in the RUN cycle. err_o and sec_wipe_acc_o come the next cycle.
- If an error and a stall coincide, the error wins.
- start_i high in the DONE cycle is ignored. It is accepted at the earliest in the following IDLE cycle.
- Reset mid-run: the next cycle is IDLE with all outputs 0. No wipe pulse.

## Test plan
- a = 2^256-1, b = 2^256-1, no stalls -> done_o at cycle 17; result_o = 2^512 - 2^257 + 1.
- a = 0x1_0000_0000_0000_0000 (2^64), b = 2^192 -> result_o = 2^256: half-word 2 = 1, others 0.
- Random a/b with stall_i asserted on steps 0, 9 and 15 for 2 cycles each -> done_o at cycle 23; fields constant while stalled; product matches the reference model.
- mac_intg_err_i pulsed at step 5 -> mac_commit_o = 0 that cycle; err_o and sec_wipe_acc_o one cycle later; result_o = 0; IDLE; no done_o.
- Check every step that mac_acc_rd_en_o == mac_en_o & ~zero_acc_o. Force mac_predec_err_i at step 0 -> abort as above.
- start_i held high continuously -> back-to-back operations 18 cycles apart; busy_o low in DONE and IDLE cycles.

Source files
------------

// File: rtl/otbn_bignum_mul_seq.sv
// Sequencer that drives the OTBN bignum MAC through a fixed 16-step quarter-word schedule,
// producing a full WLEN x WLEN -> 2*WLEN unsigned product from the shifted-out half-words.
module otbn_bignum_mul_seq #(
   parameter int unsigned WLEN = 256
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [WLEN-1:0]   operand_a_i,
   input  logic [WLEN-1:0]   operand_b_i,
   input  logic              stall_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [2*WLEN-1:0] result_o,
   output logic              mac_en_o,
   output logic              mac_commit_o,
   output logic              mac_op_en_o,
   output logic              mac_acc_rd_en_o,
   output logic [WLEN-1:0]   operand_a_o,
   output logic [WLEN-1:0]   operand_b_o,
   output logic [1:0]        a_qw_sel_o,
   output logic [1:0]        b_qw_sel_o,
   output logic [1:0]        pre_acc_shift_o,
   output logic              zero_acc_o,
   output logic              shift_acc_o,
   output logic              wr_hw_sel_upper_o,
   input  logic [WLEN-1:0]   mac_result_i,
   input  logic              mac_intg_err_i,
   input  logic              mac_predec_err_i,
   input  logic              ispr_acc_wr_en_i,
   output logic              sec_wipe_acc_o
);

   localparam int unsigned HWLEN = WLEN / 2;

   typedef enum logic [1:0] {StIdle, StRun, StDone, StAbort} state_e;

   state_e              state_q, state_d;
   logic [3:0]          step_q, step_d;
   logic [WLEN-1:0]     op_a_q, op_b_q;
   logic                op_load;
   logic [2*WLEN-1:0]   result_q, result_d;

   logic [1:0]          a_sel, b_sel, shift;
   logic                so, zero, upper;
   logic [1:0]          hw_idx;
   logic                busy, run_err, commit;

   // Only the low half of the MAC result is ever shifted out into the product.
   logic unused_mac_result;
   assign unused_mac_result = ^mac_result_i[WLEN-1:HWLEN];

   // Step schedule: {a_qw, b_qw, pre-acc shift, shift-out}
   always_comb begin
      {a_sel, b_sel, shift, so} = 7'b0;
      case (step_q)
         4'd0:  {a_sel, b_sel, shift, so} = {2'd0, 2'd0, 2'd0, 1'b0};
         4'd1:  {a_sel, b_sel, shift, so} = {2'd0, 2'd1, 2'd1, 1'b0};
         4'd2:  {a_sel, b_sel, shift, so} = {2'd1, 2'd0, 2'd1, 1'b1};
         4'd3:  {a_sel, b_sel, shift, so} = {2'd0, 2'd2, 2'd0, 1'b0};
         4'd4:  {a_sel, b_sel, shift, so} = {2'd1, 2'd1, 2'd0, 1'b0};
         4'd5:  {a_sel, b_sel, shift, so} = {2'd2, 2'd0, 2'd0, 1'b0};
         4'd6:  {a_sel, b_sel, shift, so} = {2'd0, 2'd3, 2'd1, 1'b0};
         4'd7:  {a_sel, b_sel, shift, so} = {2'd1, 2'd2, 2'd1, 1'b0};
         4'd8:  {a_sel, b_sel, shift, so} = {2'd2, 2'd1, 2'd1, 1'b0};
         4'd9:  {a_sel, b_sel, shift, so} = {2'd3, 2'd0, 2'd1, 1'b1};
         4'd10: {a_sel, b_sel, shift, so} = {2'd1, 2'd3, 2'd0, 1'b0};
         4'd11: {a_sel, b_sel, shift, so} = {2'd2, 2'd2, 2'd0, 1'b0};
         4'd12: {a_sel, b_sel, shift, so} = {2'd3, 2'd1, 2'd0, 1'b0};
         4'd13: {a_sel, b_sel, shift, so} = {2'd2, 2'd3, 2'd1, 1'b0};
         4'd14: {a_sel, b_sel, shift, so} = {2'd3, 2'd2, 2'd1, 1'b1};
         4'd15: {a_sel, b_sel, shift, so} = {2'd3, 2'd3, 2'd0, 1'b1};
      endcase
   end

   // Destination half-word of each shift-out step.
   always_comb begin
      hw_idx = 2'd0;
      case (step_q)
         4'd9:    hw_idx = 2'd1;
         4'd14:   hw_idx = 2'd2;
         4'd15:   hw_idx = 2'd3;
         default: hw_idx = 2'd0;
      endcase
   end

   assign zero    = (step_q == 4'd0);
   assign upper   = (step_q == 4'd9) || (step_q == 4'd15);
   assign busy    = (state_q == StRun);
   assign run_err = busy & (mac_intg_err_i | mac_predec_err_i | ispr_acc_wr_en_i);
   // An error overrides a stall and suppresses the commit of the failing step.
   assign commit  = busy & ~stall_i & ~run_err;

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      result_d = result_q;
      op_load  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d  = StRun;
               step_d   = 4'd0;
               result_d = '0;
               op_load  = 1'b1;
            end
         end
         StRun: begin
            if (run_err) begin
               state_d  = StAbort;
               result_d = '0;
            end else if (commit) begin
               if (so) begin
                  result_d[hw_idx*HWLEN +: HWLEN] = mac_result_i[HWLEN-1:0];
               end
               if (step_q == 4'd15) begin
                  state_d = StDone;
                  step_d  = 4'd0;
               end else begin
                  step_d = step_q + 4'd1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         StAbort: begin
            state_d = StIdle;
            step_d  = 4'd0;
         end
         default: begin
            state_d = StIdle;
            step_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         step_q   <= 4'd0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         op_a_q <= '0;
         op_b_q <= '0;
      end else if (op_load) begin
         op_a_q <= operand_a_i;
         op_b_q <= operand_b_i;
      end
   end

   assign busy_o         = busy;
   assign done_o         = (state_q == StDone);
   assign err_o          = (state_q == StAbort);
   assign sec_wipe_acc_o = (state_q == StAbort);
   assign result_o       = result_q;

   assign mac_en_o        = busy;
   assign mac_commit_o    = commit;
   assign mac_op_en_o     = busy;
   assign mac_acc_rd_en_o = busy & ~zero;

   // Everything the MAC sees is blanked outside RUN.
   assign operand_a_o       = busy ? op_a_q : '0;
   assign operand_b_o       = busy ? op_b_q : '0;
   assign a_qw_sel_o        = busy ? a_sel : 2'd0;
   assign b_qw_sel_o        = busy ? b_sel : 2'd0;
   assign pre_acc_shift_o   = busy ? shift : 2'd0;
   assign zero_acc_o        = busy & zero;
   assign shift_acc_o       = busy & so;
   assign wr_hw_sel_upper_o = busy & upper;

endmodule

// File: tb/tb_otbn_bignum_mul_seq.sv
// Directed bench for otbn_bignum_mul_seq with a behavioural bignum MAC model attached.
module tb_otbn_bignum_mul_seq;

   logic         clk, rst_n, start, stall;
   logic [255:0] op_a, op_b;
   logic         busy, done, err;
   logic [511:0] result;
   logic         mac_en, mac_commit, mac_op_en, mac_acc_rd_en;
   logic [255:0] operand_a_o, operand_b_o;
   logic [1:0]   a_sel, b_sel, pre_shift;
   logic         zero_acc, shift_acc, wr_upper;
   logic [255:0] mac_result;
   logic         intg_err, predec_err, ispr_wr, sec_wipe;

   otbn_bignum_mul_seq #(.WLEN(256)) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .start_i           (start),
      .operand_a_i       (op_a),
      .operand_b_i       (op_b),
      .stall_i           (stall),
      .busy_o            (busy),
      .done_o            (done),
      .err_o             (err),
      .result_o          (result),
      .mac_en_o          (mac_en),
      .mac_commit_o      (mac_commit),
      .mac_op_en_o       (mac_op_en),
      .mac_acc_rd_en_o   (mac_acc_rd_en),
      .operand_a_o       (operand_a_o),
      .operand_b_o       (operand_b_o),
      .a_qw_sel_o        (a_sel),
      .b_qw_sel_o        (b_sel),
      .pre_acc_shift_o   (pre_shift),
      .zero_acc_o        (zero_acc),
      .shift_acc_o       (shift_acc),
      .wr_hw_sel_upper_o (wr_upper),
      .mac_result_i      (mac_result),
      .mac_intg_err_i    (intg_err),
      .mac_predec_err_i  (predec_err),
      .ispr_acc_wr_en_i  (ispr_wr),
      .sec_wipe_acc_o    (sec_wipe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bignum MAC model: 64x64 multiply, pre-shift, accumulate, optional 128-bit shift-out.
   logic [255:0] acc;
   logic [63:0]  mac_qa, mac_qb;
   logic [255:0] mac_prod;
   always_comb begin
      mac_qa     = operand_a_o[a_sel*64 +: 64];
      mac_qb     = operand_b_o[b_sel*64 +: 64];
      mac_prod   = {192'b0, mac_qa} * {192'b0, mac_qb};
      mac_result = (zero_acc ? 256'b0 : acc) + (mac_prod << (pre_shift * 64));
   end
   always @(posedge clk) begin
      if (!rst_n || sec_wipe) acc <= '0;
      else if (mac_en && mac_commit) acc <= shift_acc ? (mac_result >> 128) : mac_result;
   end

   int exp_a  [16] = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
   int exp_b  [16] = '{0, 1, 0, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 3, 2, 3};
   int exp_sh [16] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0};
   int exp_so [16] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
   int exp_up [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int cyc;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Launch one operation; err_kind 0/1/2 selects intg/predec/ispr-write injected at err_step.
   task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [15:0] smask,
                         input int err_step, input int err_kind,
                         output int done_cyc, output int err_cyc);
      int s, si, st_cnt;
      logic exp_commit, inj;
      done_cyc = -1;
      err_cyc  = -1;
      s        = 0;
      st_cnt   = 0;
      start    = 1'b1;
      op_a     = a;
      op_b     = b;
      cyc      = 0;
      tick();
      start = 1'b0;
      while (cyc < 60 && done_cyc < 0 && err_cyc < 0) begin
         if (busy) begin
            si         = s & 15;
            stall      = smask[si] && (st_cnt < 2);
            inj        = (s == err_step);
            intg_err   = inj && (err_kind == 0);
            predec_err = inj && (err_kind == 1);
            ispr_wr    = inj && (err_kind == 2);
            #1;
            chk("a_qw_sel", a_sel, exp_a[si]);
            chk("b_qw_sel", b_sel, exp_b[si]);
            chk("pre_acc_shift", pre_shift, exp_sh[si]);
            chk("shift_acc", shift_acc, exp_so[si]);
            chk("wr_hw_sel_upper", wr_upper, exp_up[si]);
            chk("zero_acc", zero_acc, si == 0);
            chk("operand_a_o", operand_a_o, a);
            chk("mac_op_en", mac_op_en, 1'b1);
            chk("acc_rd_en", mac_acc_rd_en, mac_en & ~zero_acc);
            exp_commit = !stall && !inj;
            chk("mac_commit", mac_commit, exp_commit);
            if (exp_commit) begin
               s++;
               st_cnt = 0;
            end else if (stall) begin
               st_cnt++;
            end
         end else begin
            if (done) done_cyc = cyc;
            if (err) err_cyc = cyc;
         end
         if (done_cyc < 0 && err_cyc < 0) begin
            tick();
            stall      = 1'b0;
            intg_err   = 1'b0;
            predec_err = 1'b0;
            ispr_wr    = 1'b0;
         end
      end
   endtask

   logic [255:0] ra, rb;
   logic [511:0] prod;
   int           dc, ec, d1, d2;
   logic         b17, b18, b19;

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      stall      = 1'b0;
      op_a       = '0;
      op_b       = '0;
      intg_err   = 1'b0;
      predec_err = 1'b0;
      ispr_wr    = 1'b0;
      cyc        = 0;
      tick();
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_result", result, 512'b0);
      chk("rst_mac_en", mac_en, 1'b0);
      chk("rst_operand_b", operand_b_o, 256'b0);
      chk("rst_wipe", sec_wipe, 1'b0);
      rst_n = 1'b1;
      tick();

      // All-ones square: 2^512 - 2^257 + 1.
      run_op({256{1'b1}}, {256{1'b1}}, 16'h0000, -1, 0, dc, ec);
      chk("ones_done_cycle", dc, 17);
      chk("ones_result", result, {{63{4'hf}}, 4'he, {63{4'h0}}, 4'h1});
      chk("ones_done_busy", busy, 1'b0);
      chk("ones_done_operand_a", operand_a_o, 256'b0);
      tick();
      chk("ones_done_pulse", done, 1'b0);
      chk("ones_result_held", result, {{63{4'hf}}, 4'he, {63{4'h0}}, 4'h1});

      // 2^64 * 2^192 = 2^256: only half-word 2 set.
      run_op({191'b0, 1'b1, 64'b0}, {63'b0, 1'b1, 192'b0}, 16'h0000, -1, 0, dc, ec);
      chk("pow_done_cycle", dc, 17);
      chk("pow_result", result, {255'b0, 1'b1, 256'b0});
      tick();

      // Random operands, 2-cycle stalls on steps 0, 9 and 15.
      for (int i = 0; i < 8; i++) begin
         ra[i*32 +: 32] = $urandom;
         rb[i*32 +: 32] = $urandom;
      end
      prod = {256'b0, ra} * {256'b0, rb};
      run_op(ra, rb, 16'h8201, -1, 0, dc, ec);
      chk("stall_done_cycle", dc, 23);
      chk("stall_result", result, prod);
      tick();

      // Integrity error at step 5.
      run_op(ra, rb, 16'h0000, 5, 0, dc, ec);
      chk("intg_err_cycle", ec, 7);
      chk("intg_wipe", sec_wipe, 1'b1);
      chk("intg_result", result, 512'b0);
      chk("intg_no_done", done, 1'b0);
      tick();
      chk("intg_idle_busy", busy, 1'b0);
      chk("intg_err_pulse", err, 1'b0);
      chk("intg_wipe_pulse", sec_wipe, 1'b0);
      chk("intg_idle_done", done, 1'b0);

      // Predecode error at step 0.
      run_op(rb, ra, 16'h0000, 0, 1, dc, ec);
      chk("predec_err_cycle", ec, 2);
      chk("predec_wipe", sec_wipe, 1'b1);
      tick();

      // External ACC write at step 12, after two half-words were captured.
      run_op(ra, rb, 16'h0000, 12, 2, dc, ec);
      chk("ispr_err_cycle", ec, 14);
      chk("ispr_result", result, 512'b0);
      tick();

      // start held high: back-to-back runs, done pulses 18 cycles apart.
      d1    = -1;
      d2    = -1;
      b17   = 1'bx;
      b18   = 1'bx;
      b19   = 1'bx;
      start = 1'b1;
      cyc   = 0;
      while (cyc < 40) begin
         tick();
         if (done) begin
            if (d1 < 0) d1 = cyc;
            else if (d2 < 0) d2 = cyc;
         end
         if (cyc == 17) b17 = busy;
         if (cyc == 18) b18 = busy;
         if (cyc == 19) b19 = busy;
      end
      start = 1'b0;
      chk("b2b_first_done", d1, 17);
      chk("b2b_second_done", d2, 35);
      chk("b2b_busy_done", b17, 1'b0);
      chk("b2b_busy_idle", b18, 1'b0);
      chk("b2b_busy_run", b19, 1'b1);

      // Reset while the third back-to-back run is in progress.
      chk("midrun_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("midrun_busy", busy, 1'b0);
      chk("midrun_wipe", sec_wipe, 1'b0);
      chk("midrun_err", err, 1'b0);
      chk("midrun_mac_en", mac_en, 1'b0);
      chk("midrun_result", result, 512'b0);
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
